// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver with synchroniser, 3-sample majority vote, optional parity and framing-error pulse.
module uart_cmd_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [8:0] rs232_data,
    output logic       rs232_flag,
    output logic       frame_err,
    output logic       busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int MID = BAUD_DIV / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    state_t      state_q, state_d;
    logic        rx_s1_q, rx_s_q, rx_prev_q;
    logic [2:0]  vld_q;
    logic [15:0] bcnt_q, bcnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  smp_q, smp_d;
    logic        perr_q, perr_d;
    logic [8:0]  data_q, data_d;
    logic        flag_q, flag_d, ferr_q, ferr_d;
    logic        fall, vote, at_mid1, at_end;

    // vld_q marks when rx_prev_q holds a real line sample, so a line low out of reset is not an edge
    assign fall    = vld_q[2] & rx_prev_q & ~rx_s_q;
    assign vote    = (smp_q[0] & smp_q[1]) | (rx_s_q & (smp_q[0] | smp_q[1]));
    assign at_mid1 = bcnt_q == 16'(MID + 1);
    assign at_end  = bcnt_q == 16'(BAUD_DIV - 1);

    always_comb begin
        state_d  = state_q;
        bcnt_d   = at_end ? 16'd0 : bcnt_q + 16'd1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        data_d   = data_q;
        flag_d   = 1'b0;
        ferr_d   = 1'b0;
        smp_d[0] = (bcnt_q == 16'(MID - 1)) ? rx_s_q : smp_q[0];
        smp_d[1] = (bcnt_q == 16'(MID)) ? rx_s_q : smp_q[1];
        case (state_q)
            IDLE: begin
                bcnt_d = 16'd0;
                if (fall) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    idx_d   = 3'd0;
                end
            end
            START: begin
                if (at_mid1 && vote) begin
                    state_d = IDLE;
                    bcnt_d  = 16'd0;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_mid1) shift_d = {vote, shift_q[7:1]};
                if (at_end) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_mid1) perr_d = ^shift_q ^ vote ^ 1'(PARITY_ODD);
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_mid1) begin
                    bcnt_d  = 16'd0;
                    state_d = vote ? IDLE : WAIT_HIGH;
                    flag_d  = vote;
                    ferr_d  = ~vote;
                    data_d  = vote ? {perr_q, shift_q} : data_q;
                end
            end
            WAIT_HIGH: begin
                bcnt_d = 16'd0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            vld_q     <= 3'd0;
            state_q   <= IDLE;
            bcnt_q    <= 16'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            smp_q     <= 2'd0;
            perr_q    <= 1'b0;
            data_q    <= 9'd0;
            flag_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s_q    <= rx_s1_q;
            rx_prev_q <= rx_s_q;
            vld_q     <= {vld_q[1:0], 1'b1};
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            flag_q    <= flag_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rs232_data = data_q;
    assign rs232_flag = flag_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed frames into a plain and a parity-enabled receiver, checked against hand-computed values.
module tb_uart_cmd_rx;
    localparam int BD = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic       psel = 1'b0;
    logic       rx0, rx1;
    logic [8:0] d0, d1;
    logic       f0, e0, b0, f1, e1, b1;

    int passed = 0, total = 0;
    int cyc = 0, nflag0 = 0, nferr0 = 0, bf0 = 0, dbl0 = 0, nflag1 = 0;
    int fprev = 0, flast = 0;
    logic pf0 = 1'b0;

    assign rx0 = psel ? 1'b1 : line;
    assign rx1 = psel ? line : 1'b1;

    always #10 clk = ~clk;

    uart_cmd_rx dut (
        .clk(clk), .rst_n(rst_n), .rx(rx0),
        .rs232_data(d0), .rs232_flag(f0), .frame_err(e0), .busy(b0)
    );

    uart_cmd_rx #(.PARITY_EN(1), .PARITY_ODD(0)) dutp (
        .clk(clk), .rst_n(rst_n), .rx(rx1),
        .rs232_data(d1), .rs232_flag(f1), .frame_err(e1), .busy(b1)
    );

    always @(negedge clk) begin
        cyc++;
        if (f0) begin
            nflag0++;
            if (b0) bf0++;
            if (pf0) dbl0++;
            fprev = flast;
            flast = cyc;
        end
        if (e0) nferr0++;
        pf0 = f0;
        if (f1) nflag1++;
    end

    // bits are LSB first: start at [0], stop at [nbits-1]; gl is the cycle whose level is inverted
    task automatic send(input logic [11:0] bits, input int nbits, input int gl);
        for (int c = 0; c < nbits * BD; c++) begin
            @(negedge clk);
            line = bits[c / BD] ^ (c == gl);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            line = 1'b1;
        end
    endtask

    function automatic logic [11:0] fr8(input logic [7:0] b);
        return {3'b111, b, 1'b0};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        line = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({d0, f0, e0, b0} !== 12'd0) $display("FAIL reset_outputs: got %h want 000", {d0, f0, e0, b0});
        else passed++;
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        total++;
        if (b0 !== 1'b0 || nflag0 != 0) $display("FAIL low_from_reset: busy %b flags %0d want 0 0", b0, nflag0);
        else passed++;
        idle(100);
    endtask

    task automatic test_single;
        send(fr8(8'h11), 10, -1);
        idle(20);
        total++;
        if (nflag0 != 1) $display("FAIL single_flag: got %0d want 1", nflag0); else passed++;
        total++;
        if (d0 !== 9'h011) $display("FAIL single_data: got %h want 011", d0); else passed++;
        total++;
        if (nferr0 != 0 || bf0 != 0) $display("FAIL single_ferr_busy: ferr %0d busyflag %0d want 0 0", nferr0, bf0); else passed++;
    endtask

    task automatic test_back_to_back;
        int n;
        n = nflag0;
        send(fr8(8'h1F), 10, -1);
        total++;
        if (d0 !== 9'h01F) $display("FAIL b2b_first: got %h want 01f", d0); else passed++;
        send(fr8(8'h19), 10, -1);
        idle(20);
        total++;
        if (d0 !== 9'h019 || nflag0 != n + 2) $display("FAIL b2b_second: data %h flags %0d want 019 %0d", d0, nflag0, n + 2); else passed++;
        total++;
        if (flast - fprev != 10 * BD) $display("FAIL b2b_spacing: got %0d want %0d", flast - fprev, 10 * BD); else passed++;
        total++;
        if (dbl0 != 0) $display("FAIL flag_width: got %0d double cycles want 0", dbl0); else passed++;
    endtask

    task automatic test_glitch;
        int n, ne;
        n = nflag0;
        ne = nferr0;
        repeat (50) begin @(negedge clk); line = 1'b0; end
        total++;
        if (b0 !== 1'b1) $display("FAIL glitch_start: busy %b want 1", b0); else passed++;
        repeat (50) begin @(negedge clk); line = 1'b0; end
        idle(1000);
        total++;
        if (nflag0 != n || nferr0 != ne || d0 !== 9'h019 || b0 !== 1'b0)
            $display("FAIL glitch_reject: flags %0d ferr %0d data %h busy %b want %0d %0d 019 0", nflag0, nferr0, d0, b0, n, ne);
        else passed++;
    endtask

    task automatic test_frame_err;
        int n;
        n = nflag0;
        send({3'b000, 8'h1A, 1'b0}, 10, -1);
        repeat (2000) begin @(negedge clk); line = 1'b0; end
        total++;
        if (nferr0 != 1 || nflag0 != n || d0 !== 9'h019)
            $display("FAIL frame_err: ferr %0d flags %0d data %h want 1 %0d 019", nferr0, nflag0, d0, n);
        else passed++;
        total++;
        if (b0 !== 1'b1) $display("FAIL wait_high_busy: got %b want 1", b0); else passed++;
        idle(20);
        total++;
        if (b0 !== 1'b0) $display("FAIL wait_high_exit: got %b want 0", b0); else passed++;
        send(fr8(8'h12), 10, -1);
        idle(20);
        total++;
        if (d0 !== 9'h012 || nflag0 != n + 1) $display("FAIL after_ferr: data %h flags %0d want 012 %0d", d0, nflag0, n + 1); else passed++;
    endtask

    task automatic test_data_glitch;
        int n;
        n = nflag0;
        send(fr8(8'h1F), 10, 4 * BD + BD / 2);
        idle(20);
        total++;
        if (d0 !== 9'h01F || nflag0 != n + 1) $display("FAIL majority: data %h flags %0d want 01f %0d", d0, nflag0, n + 1); else passed++;
    endtask

    task automatic test_parity;
        psel = 1'b1;
        send({2'b11, 1'b0, 8'h11, 1'b0}, 11, -1);
        idle(20);
        total++;
        if (d1 !== 9'h011) $display("FAIL parity_ok: got %h want 011", d1); else passed++;
        send({2'b11, 1'b1, 8'h11, 1'b0}, 11, -1);
        idle(20);
        total++;
        if (d1 !== 9'h111) $display("FAIL parity_err: got %h want 111", d1); else passed++;
        chk("parity_flags", nflag1, 2);
        psel = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n, ne;
        logic [11:0] b;
        b = fr8(8'h11);
        n = nflag0;
        ne = nferr0;
        for (int c = 0; c < 4 * BD + BD + 200; c++) begin
            @(negedge clk);
            line = b[c / BD];
        end
        total++;
        if (b0 !== 1'b1) $display("FAIL mid_busy: got %b want 1", b0); else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({d0, f0, e0, b0} !== 12'd0) $display("FAIL mid_reset: got %h want 000", {d0, f0, e0, b0}); else passed++;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(12 * BD);
        total++;
        if (nflag0 != n || nferr0 != ne) $display("FAIL aborted_frame: flags %0d ferr %0d want %0d %0d", nflag0, nferr0, n, ne); else passed++;
        send(fr8(8'h11), 10, -1);
        idle(20);
        total++;
        if (d0 !== 9'h011 || nflag0 != n + 1) $display("FAIL after_reset: data %h flags %0d want 011 %0d", d0, nflag0, n + 1); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_data_glitch;
        test_parity;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
